// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 scan counters, blanking, and one-cycle-registered VGA pin stage.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [3:0] pix_red,
  input  logic [3:0] pix_green,
  input  logic [3:0] pix_blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  localparam logic [9:0] HT1 = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VT1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] HSS = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSE = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSS = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSE = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic       h_wrap, v_wrap, hs_raw, vs_raw;
  logic       hs_q, vs_q, fs_q;
  logic [3:0] r_q, g_q, b_q;
  logic [7:0] fc_q;
  always_comb begin
    h_wrap = hc_q == HT1;
    v_wrap = vc_q == VT1;
    hc_d   = h_wrap ? 10'd0 : hc_q + 10'd1;
    vc_d   = h_wrap ? (v_wrap ? 10'd0 : vc_q + 10'd1) : vc_q;
    blank  = (hc_q < HA) && (vc_q < VA);
    hs_raw = !((hc_q >= HSS) && (hc_q < HSE));
    vs_raw = !((vc_q >= VSS) && (vc_q < VSE));
  end
  // sync and colour share one register stage so the pins stay mutually aligned
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q <= '0;
      vc_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      fs_q <= 1'b0;
      fc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      hs_q <= hs_raw;
      vs_q <= vs_raw;
      r_q  <= blank ? pix_red   : 4'h0;
      g_q  <= blank ? pix_green : 4'h0;
      b_q  <= blank ? pix_blue  : 4'h0;
      fs_q <= h_wrap && v_wrap;
      fc_q <= fc_q + {7'd0, h_wrap && v_wrap};
    end
  end
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: a shrunk-timing instance and a default-timing instance, both checked every cycle against an arithmetic scan model.
module tb_vga_timing_gen;
  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 4, SVA = 10, SVF = 2, SVS = 2, SVB = 3;
  typedef struct packed {
    logic [9:0] x, y;
    logic       bl, hs, vs;
    logic [3:0] r, g, b;
    logic       fs;
    logic [7:0] fc;
  } vis_t;
  logic clk = 0;
  logic rst_n = 1;
  logic [3:0] pr_s = 0, pg_s = 0, pb_s = 0, pr_d = 0, pg_d = 0, pb_d = 0;
  logic [9:0] x_s, y_s, x_d, y_d;
  logic bl_s, hs_s, vs_s, fs_s, bl_d, hs_d, vs_d, fs_d;
  logic [3:0] r_s, g_s, b_s, r_d, g_d, b_d;
  logic [7:0] fc_s, fc_d;
  logic [11:0] pp_s, pp_d;
  int t = 0;
  int checks = 0, errors = 0;
  bit run1 = 1;
  int first_hs_s = -1, hs_low_s = 0, hs_low_d = 0, first_fs = -1, fs_x = -1, fs_y = -1;
  int fall_d[2] = '{-1, -1};
  int nfall_d = 0, f_cnt = 0, vs_low = 0, fc_1020 = -1, vr_1112 = -1;
  logic prev_hs_d = 1;

  vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) dut_s (
    .vga_clk(clk), .reset_n(rst_n), .pix_red(pr_s), .pix_green(pg_s), .pix_blue(pb_s),
    .DrawX(x_s), .DrawY(y_s), .blank(bl_s), .hs(hs_s), .vs(vs_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .frame_start(fs_s), .frame_count(fc_s));
  vga_timing_gen dut_d (
    .vga_clk(clk), .reset_n(rst_n), .pix_red(pr_d), .pix_green(pg_d), .pix_blue(pb_d),
    .DrawX(x_d), .DrawY(y_d), .blank(bl_d), .hs(hs_d), .vs(vs_d),
    .vga_r(r_d), .vga_g(g_d), .vga_b(b_d), .frame_start(fs_d), .frame_count(fc_d));

  always #5 clk = ~clk;

  // Expected visible state after t rising edges since reset; pp is the colour sampled on the latest edge.
  function automatic vis_t model(int tt, logic [11:0] pp, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb);
    int ht = ha + hf + hsw + hb, vt = va + vf + vsw + vb, fr, px, py;
    vis_t e;
    fr = ht * vt;
    e.x = 10'(tt % ht);
    e.y = 10'((tt / ht) % vt);
    e.bl = (tt % ht < ha) && ((tt / ht) % vt < va);
    e.hs = 1; e.vs = 1; e.r = 0; e.g = 0; e.b = 0;
    if (tt > 0) begin
      px = (tt - 1) % ht;
      py = ((tt - 1) / ht) % vt;
      e.hs = !(px >= ha + hf && px < ha + hf + hsw);
      e.vs = !(py >= va + vf && py < va + vf + vsw);
      if (px < ha && py < va) {e.r, e.g, e.b} = pp;
    end
    e.fs = tt > 0 && tt % fr == 0;
    e.fc = 8'((tt / fr) % 256);
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  always @(posedge clk or negedge rst_n) t <= !rst_n ? 0 : t + 1;
  always @(posedge clk) begin
    pp_s <= {pr_s, pg_s, pb_s};
    pp_d <= {pr_d, pg_d, pb_d};
  end

  always @(negedge clk) begin
    vis_t es, ed, as_, ad;
    es = model(t, pp_s, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
    ed = model(t, pp_d, 640, 16, 96, 48, 480, 10, 2, 33);
    as_ = {x_s, y_s, bl_s, hs_s, vs_s, r_s, g_s, b_s, fs_s, fc_s};
    ad = {x_d, y_d, bl_d, hs_d, vs_d, r_d, g_d, b_d, fs_d, fc_d};
    checks += 2;
    if (as_ !== es) begin
      errors++;
      $display("FAIL small t=%0d: got %h expected %h", t, as_, es);
    end
    if (ad !== ed) begin
      errors++;
      $display("FAIL default t=%0d: got %h expected %h", t, ad, ed);
    end
    if (run1 && t > 0) begin
      if (!hs_s && first_hs_s < 0) first_hs_s = t;
      if (t <= 30 && !hs_s) hs_low_s++;
      if (t <= 800 && !hs_d) hs_low_d++;
      if (prev_hs_d && !hs_d && nfall_d < 2) begin
        fall_d[nfall_d] = t;
        nfall_d++;
      end
      if (fs_s && first_fs < 0) begin
        first_fs = t;
        fs_x = int'(x_s);
        fs_y = int'(y_s);
      end
      if (t >= 511 && t <= 1020 && r_s == 4'hF && g_s == 4'hF && b_s == 4'hF) f_cnt++;
      if (t >= 511 && t <= 1020 && !vs_s) vs_low++;
      if (t == 1020) fc_1020 = int'(fc_s);
      if (t == 1112) vr_1112 = int'(r_s);
    end
    prev_hs_d = hs_d;
    pr_d = 4'($urandom); pg_d = 4'($urandom); pb_d = 4'($urandom);
    pr_s = 4'($urandom); pg_s = 4'($urandom); pb_s = 4'($urandom);
    if (t >= 500 && t < 1100) {pr_s, pg_s, pb_s} = 12'hFFF;
    else if (t >= 1100) pr_s = x_s[3:0];
  end

  initial begin
    #1 rst_n = 0;
    repeat (5) @(negedge clk);
    chk("reset_drawx", int'(x_s), 0);
    chk("reset_blank", int'(bl_s), 1);
    chk("reset_hs_vs", int'({hs_s, vs_s}), 3);
    chk("reset_rgb", int'({r_s, g_s, b_s}), 0);
    chk("reset_frame_start", int'(fs_s), 0);
    rst_n = 1;
    while (t != 1687) @(negedge clk);
    chk("pre_reset_drawx", int'(x_s), 7);
    chk("pre_reset_drawy", int'(y_s), 5);
    run1 = 0;
    #2 rst_n = 0;
    #1;
    chk("async_drawx", int'(x_s), 0);
    chk("async_drawy", int'(y_s), 0);
    chk("async_hs_vs", int'({hs_s, vs_s, hs_d, vs_d}), 15);
    chk("async_frame_count", int'(fc_s), 0);
    chk("async_rgb", int'({r_s, g_s, b_s}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("restart_drawx", int'(x_s), i);
      chk("restart_drawy", int'(y_s), 0);
    end
    repeat (40) @(negedge clk);
    chk("first_hs_low_small", first_hs_s, 21);
    chk("hs_low_per_line_small", hs_low_s, 6);
    chk("first_hs_fall_default", fall_d[0], 657);
    chk("hs_period_default", fall_d[1] - fall_d[0], 800);
    chk("hs_low_per_line_default", hs_low_d, 96);
    chk("first_frame_start", first_fs, 510);
    chk("frame_start_at_origin", fs_x + fs_y, 0);
    chk("frame_count_two_frames", fc_1020, 2);
    chk("white_pixels_per_frame", f_cnt, 160);
    chk("vs_low_per_frame", vs_low, 60);
    chk("aligned_red", vr_1112, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
